// File: rtl/display_pkg.sv
// Shared display constants and types for the scrolling HEX/LEDR datapath.
// Segment codes are active-low and ordered {g,f,e,d,c,b,a}, which matches the
// board's seven-segment displays. CLOCK_CYCLE is the clock period used by benches.
package display_pkg;

  localparam int CLOCK_CYCLE = 10;

  localparam logic [6:0] HEX_OFF = 7'b1111111;
  localparam logic [6:0] HEX_0   = 7'b1000000;
  localparam logic [6:0] HEX_1   = 7'b1111001;
  localparam logic [6:0] HEX_3   = 7'b0110000;
  localparam logic [6:0] HEX_C   = 7'b1000110;
  localparam logic [6:0] HEX_E   = 7'b0000110;
  localparam logic [6:0] HEX_N   = 7'b0101011;
  localparam logic [6:0] HEX_P   = 7'b0001100;

  localparam logic [9:0] LEDR_0 = 10'b0000000001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/ledr_pattern.sv
// One-hot LED bar pattern generator.
// Ports:
//   clk, reset - clock and asynchronous active-high reset
//   en         - advance the pattern one position on this edge
//   mode       - 0 = rotate toward the MSB, 1 = bounce between the ends
//   pattern    - registered one-hot LED pattern (bit 0 set after reset)
module ledr_pattern #(
  parameter int LED_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  output logic [LED_W-1:0] pattern
);

  localparam logic [LED_W-1:0] START = {{(LED_W-1){1'b0}}, 1'b1};

  logic [LED_W-1:0] ledr_r;
  logic             down_r;

  // Rotate/bounce state; rotate mode forces the bounce direction back to "up"
  // so the next bounce always starts climbing from wherever the bit sits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ledr_r <= START;
      down_r <= 1'b0;
    end else if (!mode) begin
      down_r <= 1'b0;
      if (en) begin
        ledr_r <= {ledr_r[LED_W-2:0], ledr_r[LED_W-1]};
      end else begin
        ledr_r <= ledr_r;
      end
    end else if (en) begin
      if (!down_r) begin
        if (ledr_r[LED_W-1]) begin
          down_r <= 1'b1;
          ledr_r <= {1'b0, ledr_r[LED_W-1:1]};
        end else begin
          ledr_r <= {ledr_r[LED_W-2:0], 1'b0};
        end
      end else begin
        if (ledr_r[0]) begin
          down_r <= 1'b0;
          ledr_r <= {ledr_r[LED_W-2:0], 1'b0};
        end else begin
          ledr_r <= {1'b0, ledr_r[LED_W-1:1]};
        end
      end
    end else begin
      ledr_r <= ledr_r;
    end
  end

  assign pattern = ledr_r;

endmodule

// File: rtl/scroll_window_datapath.sv
// Scrolling message display datapath: a circular buffer of segment codes and
// an N-digit window into it. A refresh fetches the window one digit per clock
// into a staging register, then commits every digit to the HEX outputs at once.
// Ports:
//   clk, reset         - clock and asynchronous active-high reset
//   wr_en/addr/data    - message buffer write port
//   msg_len            - active message length (0..MSG_DEPTH)
//   step/load/dir      - advance-and-refresh / refresh request, scroll direction
//   ledr_en/led_mode   - LED bar advance and rotate(0)/bounce(1) select
//   current_hex        - committed digits, digit 0 rightmost in the low bits
//   current_ledr       - one-hot LED bar
//   busy               - window fetch in progress
//   wrap               - one-cycle pulse at the commit of a wrapping step
module scroll_window_datapath
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_DEPTH  = 16,
  parameter int SEG_W      = 7,
  parameter int LED_W      = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0]  wr_addr,
  input  logic [SEG_W-1:0]              wr_data,
  input  logic [$clog2(MSG_DEPTH):0]    msg_len,
  input  logic                          step,
  input  logic                          load,
  input  logic                          dir,
  input  logic                          ledr_en,
  input  logic                          led_mode,
  output logic [NUM_DIGITS*SEG_W-1:0]   current_hex,
  output logic [LED_W-1:0]              current_ledr,
  output logic                          busy,
  output logic                          wrap
);

  localparam int PTR_W = $clog2(MSG_DEPTH);
  localparam int LEN_W = PTR_W + 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SEG_W-1:0] OFF_CODE = SEG_W'(HEX_OFF);

  logic [SEG_W-1:0]            msg_buf_r [MSG_DEPTH];
  state_t                      state_r;
  logic [PTR_W-1:0]            ptr_r;
  logic [PTR_W-1:0]            rd_r;
  logic [LEN_W-1:0]            len_r;
  logic [IDX_W-1:0]            idx_r;
  logic [NUM_DIGITS*SEG_W-1:0] stage_r;
  logic [NUM_DIGITS*SEG_W-1:0] hex_r;
  logic                        busy_r;
  logic                        wrap_r;
  logic                        wrap_pend_r;
  logic                        pend_r;
  logic                        pend_load_r;
  logic                        pend_dir_r;

  logic                        req_s;
  logic                        start_s;
  logic                        src_load_s;
  logic                        src_dir_s;
  logic [PTR_W-1:0]            base_s;
  logic [LEN_W-1:0]            len_last_s;
  logic [PTR_W-1:0]            nptr_s;
  logic                        nwrap_s;
  logic [IDX_W-1:0]            dig_s;
  logic [SEG_W-1:0]            fetch_code_s;

  // Message buffer: contents survive reset; reads are combinational so a
  // same-cycle write to the address being fetched is seen only next cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      msg_buf_r[wr_addr] <= wr_data;
    end
  end

  // Start decision and next-pointer arithmetic. At COMMIT a fresh request
  // overrides the stored pending one, matching "latest request wins".
  always_comb begin
    req_s      = step | load;
    start_s    = 1'b0;
    src_load_s = load;
    src_dir_s  = dir;
    nptr_s     = {PTR_W{1'b0}};
    nwrap_s    = 1'b0;
    len_last_s = msg_len - LEN_W'(1);
    dig_s      = IDX_W'(NUM_DIGITS - 1) - idx_r;

    if (state_r == IDLE) begin
      start_s = req_s;
    end else if (state_r == COMMIT) begin
      start_s = req_s | pend_r;
      if (!req_s) begin
        src_load_s = pend_load_r;
        src_dir_s  = pend_dir_r;
      end else begin
        src_load_s = load;
      end
    end else begin
      start_s = 1'b0;
    end

    // A pointer left beyond a shrunken message restarts at 0 before moving.
    if ({1'b0, ptr_r} >= msg_len) begin
      base_s = {PTR_W{1'b0}};
    end else begin
      base_s = ptr_r;
    end

    if (msg_len == {LEN_W{1'b0}}) begin
      nptr_s  = {PTR_W{1'b0}};
      nwrap_s = 1'b0;
    end else if (src_load_s) begin
      nptr_s  = base_s;
      nwrap_s = 1'b0;
    end else if (!src_dir_s) begin
      if ({1'b0, base_s} == len_last_s) begin
        nptr_s  = {PTR_W{1'b0}};
        nwrap_s = 1'b1;
      end else begin
        nptr_s  = base_s + PTR_W'(1);
        nwrap_s = 1'b0;
      end
    end else begin
      if (base_s == {PTR_W{1'b0}}) begin
        nptr_s  = len_last_s[PTR_W-1:0];
        nwrap_s = 1'b1;
      end else begin
        nptr_s  = base_s - PTR_W'(1);
        nwrap_s = 1'b0;
      end
    end

    if (len_r == {LEN_W{1'b0}}) begin
      fetch_code_s = OFF_CODE;
    end else begin
      fetch_code_s = msg_buf_r[rd_r];
    end
  end

  // Window fetch FSM: stage one digit per clock, then commit all digits together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      ptr_r       <= {PTR_W{1'b0}};
      rd_r        <= {PTR_W{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      stage_r     <= {NUM_DIGITS{OFF_CODE}};
      hex_r       <= {NUM_DIGITS{OFF_CODE}};
      busy_r      <= 1'b0;
      wrap_r      <= 1'b0;
      wrap_pend_r <= 1'b0;
      pend_r      <= 1'b0;
      pend_load_r <= 1'b0;
      pend_dir_r  <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            ptr_r       <= nptr_s;
            rd_r        <= nptr_s;
            len_r       <= msg_len;
            idx_r       <= {IDX_W{1'b0}};
            wrap_pend_r <= nwrap_s;
            busy_r      <= 1'b1;
            state_r     <= FETCH;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        FETCH: begin
          stage_r[dig_s*SEG_W +: SEG_W] <= fetch_code_s;
          idx_r <= idx_r + IDX_W'(1);
          // rd_r walks the circular message so no modulo is needed.
          if ({1'b0, rd_r} == len_r - LEN_W'(1)) begin
            rd_r <= {PTR_W{1'b0}};
          end else begin
            rd_r <= rd_r + PTR_W'(1);
          end
          if (idx_r == IDX_W'(NUM_DIGITS - 1)) begin
            state_r <= COMMIT;
          end else begin
            state_r <= FETCH;
          end
          if (req_s) begin
            pend_r      <= 1'b1;
            pend_load_r <= load;
            pend_dir_r  <= dir;
          end else begin
            pend_r <= pend_r;
          end
        end
        COMMIT: begin
          hex_r  <= stage_r;
          wrap_r <= wrap_pend_r;
          pend_r <= 1'b0;
          if (start_s) begin
            ptr_r       <= nptr_s;
            rd_r        <= nptr_s;
            len_r       <= msg_len;
            idx_r       <= {IDX_W{1'b0}};
            wrap_pend_r <= nwrap_s;
            busy_r      <= 1'b1;
            state_r     <= FETCH;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          pend_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  ledr_pattern #(.LED_W(LED_W)) u_ledr (
    .clk     (clk),
    .reset   (reset),
    .en      (ledr_en),
    .mode    (led_mode),
    .pattern (current_ledr)
  );

  assign current_hex = hex_r;
  assign busy        = busy_r;
  assign wrap        = wrap_r;

endmodule

// File: tb/tb_scroll_window_datapath.sv
module tb_scroll_window_datapath;
  import display_pkg::*;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [6:0]  wr_data;
  logic [4:0]  msg_len;
  logic        step;
  logic        load;
  logic        dir;
  logic        ledr_en;
  logic        led_mode;
  logic [41:0] current_hex;
  logic [9:0]  current_ledr;
  logic        busy;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  scroll_window_datapath dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .msg_len      (msg_len),
    .step         (step),
    .load         (load),
    .dir          (dir),
    .ledr_en      (ledr_en),
    .led_mode     (led_mode),
    .current_hex  (current_hex),
    .current_ledr (current_ledr),
    .busy         (busy),
    .wrap         (wrap)
  );

  initial clk = 1'b0;
  always #(CLOCK_CYCLE/2) clk = ~clk;

  typedef struct {
    logic [4:0]  len;
    logic        stp;
    logic        ld;
    logic        d;
    logic [41:0] hex;
    int          wraps;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [4:0] len, input logic stp, input logic ld,
                         input logic d, input logic [41:0] hex, input int wraps);
    vecs[i].len = len; vecs[i].stp = stp; vecs[i].ld = ld;
    vecs[i].d = d; vecs[i].hex = hex; vecs[i].wraps = wraps;
  endtask

  // One request from idle: checks busy length, wrap pulse count and committed digits.
  task automatic run_op(input string name, input logic [4:0] len, input logic stp, input logic ld,
                        input logic d, input logic [41:0] exp_hex, input int exp_wraps);
    int n;
    int w;
    n = 0;
    w = 0;
    msg_len = len; step = stp; load = ld; dir = d;
    tick();
    step = 1'b0; load = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (wrap) w++;
      if (!busy) break;
      n++;
      tick();
    end
    chk({name, " busy_cycles"}, 64'(n), 64'(7));
    chk({name, " hex"}, 64'(current_hex), 64'(exp_hex));
    tick();
    if (wrap) w++;
    chk({name, " wrap_pulses"}, 64'(w), 64'(exp_wraps));
  endtask

  logic [41:0] w_cpeno3, w_peno3o, w_1cpeno, w_cccccc, w_off, w_eno3o1, w_cpcpcp;
  logic [6:0]  msg [8];
  logic [9:0]  exp_led;
  logic [41:0] mid_hex;
  int          n;
  int          cnt;
  int          pos;

  initial begin
    w_cpeno3 = {HEX_C, HEX_P, HEX_E, HEX_N, HEX_OFF, HEX_3};
    w_peno3o = {HEX_P, HEX_E, HEX_N, HEX_OFF, HEX_3, HEX_OFF};
    w_1cpeno = {HEX_1, HEX_C, HEX_P, HEX_E, HEX_N, HEX_OFF};
    w_cccccc = {HEX_C, HEX_C, HEX_C, HEX_C, HEX_C, HEX_C};
    w_off    = {HEX_OFF, HEX_OFF, HEX_OFF, HEX_OFF, HEX_OFF, HEX_OFF};
    w_eno3o1 = {HEX_E, HEX_N, HEX_OFF, HEX_3, HEX_OFF, HEX_1};
    w_cpcpcp = {HEX_C, HEX_P, HEX_C, HEX_P, HEX_C, HEX_P};
    msg[0] = HEX_C; msg[1] = HEX_P; msg[2] = HEX_E; msg[3] = HEX_N;
    msg[4] = HEX_OFF; msg[5] = HEX_3; msg[6] = HEX_OFF; msg[7] = HEX_1;

    set_vec(0,  5'd8, 1'b0, 1'b1, 1'b0, w_cpeno3, 0);  // load at ptr 0
    set_vec(1,  5'd8, 1'b1, 1'b0, 1'b0, w_peno3o, 0);  // left -> ptr 1
    set_vec(2,  5'd8, 1'b1, 1'b0, 1'b1, w_cpeno3, 0);  // right -> ptr 0
    set_vec(3,  5'd8, 1'b1, 1'b0, 1'b1, w_1cpeno, 1);  // right wrap -> ptr 7
    set_vec(4,  5'd8, 1'b1, 1'b0, 1'b0, w_cpeno3, 1);  // left wrap -> ptr 0
    set_vec(5,  5'd8, 1'b1, 1'b1, 1'b0, w_cpeno3, 0);  // load beats step
    set_vec(6,  5'd1, 1'b1, 1'b0, 1'b0, w_cccccc, 1);  // len 1 always wraps
    set_vec(7,  5'd1, 1'b1, 1'b0, 1'b1, w_cccccc, 1);
    set_vec(8,  5'd0, 1'b0, 1'b1, 1'b0, w_off,    0);  // empty message
    set_vec(9,  5'd8, 1'b1, 1'b0, 1'b0, w_peno3o, 0);  // ptr 1
    set_vec(10, 5'd8, 1'b1, 1'b0, 1'b0, w_eno3o1, 0);  // ptr 2
    set_vec(11, 5'd2, 1'b0, 1'b1, 1'b0, w_cpcpcp, 0);  // shrink: ptr 2 -> 0

    reset = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 7'd0; msg_len = 5'd0;
    step = 1'b0; load = 1'b0; dir = 1'b0; ledr_en = 1'b0; led_mode = 1'b0;
    tick();
    tick();
    chk("reset hex", 64'(current_hex), 64'(w_off));
    chk("reset ledr", 64'(current_ledr), 64'(LEDR_0));
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset wrap", 64'(wrap), 64'd0);
    reset = 1'b0;
    tick();

    // LED bar: bounce 12 steps, then rotate 5 steps.
    led_mode = 1'b1; ledr_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      pos = (i + 1 <= 9) ? (i + 1) : (18 - (i + 1));
      exp_led = 10'd1 << pos;
      chk("ledr bounce", 64'(current_ledr), 64'(exp_led));
    end
    led_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pos = (7 + i) % 10;
      exp_led = 10'd1 << pos;
      chk("ledr rotate", 64'(current_ledr), 64'(exp_led));
    end
    ledr_en = 1'b0;

    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = msg[i];
      tick();
    end
    wr_en = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].len, vecs[i].stp, vecs[i].ld, vecs[i].d,
             vecs[i].hex, vecs[i].wraps);
    end

    // Two steps while busy collapse into one extra fetch right after COMMIT.
    msg_len = 5'd8; dir = 1'b0; step = 1'b1;
    tick();
    step = 1'b0;
    n = 0;
    mid_hex = 42'd0;
    for (int c = 0; c < 60; c++) begin
      if (!busy) break;
      n++;
      if (n == 10) mid_hex = current_hex;
      step = (c == 1 || c == 3) ? 1'b1 : 1'b0;
      tick();
    end
    step = 1'b0;
    chk("pending busy_cycles", 64'(n), 64'd14);
    chk("pending mid hex", 64'(mid_hex), 64'(w_peno3o));
    chk("pending final hex", 64'(current_hex), 64'(w_eno3o1));
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (busy) cnt++;
    end
    chk("pending no third fetch", 64'(cnt), 64'd0);

    // Reset in the middle of a fetch clears outputs without a clock edge.
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("midreset hex", 64'(current_hex), 64'(w_off));
    chk("midreset ledr", 64'(current_ledr), 64'(LEDR_0));
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset wrap", 64'(wrap), 64'd0);
    #1;
    reset = 1'b0;
    tick();
    chk("postreset idle", 64'(busy), 64'd0);
    run_op("postreset load", 5'd8, 1'b0, 1'b1, 1'b0, w_cpeno3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scroll_window_datapath.md
Name: scroll_window_datapath

Overview:
- Parametrised successor to the fixed six-digit display datapath.
- Holds a circular message buffer of segment codes and an N-digit window into it; on request, fetches the window digit-by-digit and commits all digits to the HEX outputs at once, so the display never tears mid-update.
- Also drives a one-hot LEDR bar with rotate or bounce modes.
- Sits between the scroll-control FSM/tick divider and the top-level HEX/LEDR pins.

Parameters:
- NUM_DIGITS, 6, number of HEX digits in the window (1..8)
- MSG_DEPTH, 16, message buffer entries (power of two, >= NUM_DIGITS)
- SEG_W, 7, bits per segment code
- LED_W, 10, LEDR bar width (>= 2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write message buffer entry this cycle
- wr_addr  in  $clog2(MSG_DEPTH)  buffer write index
- wr_data  in  SEG_W  segment code to write
- msg_len  in  $clog2(MSG_DEPTH)+1  active message length, 0..MSG_DEPTH
- step  in  1  advance pointer one position, then refresh the window
- load  in  1  refresh the window without moving the pointer
- dir  in  1  0 = scroll left (ptr+1), 1 = scroll right (ptr-1)
- ledr_en  in  1  advance the LEDR pattern one position
- led_mode  in  1  0 = rotate, 1 = bounce
- current_hex  out  NUM_DIGITS*SEG_W  digit d occupies bits [d*SEG_W +: SEG_W]; digit 0 is the rightmost
- current_ledr  out  LED_W  one-hot LED pattern
- busy  out  1  window fetch in progress
- wrap  out  1  one-cycle pulse when the pointer wraps

Behaviour:
- Reset values:
  - every digit = HEX_OFF
  - current_ledr = LEDR_0 (bit 0 set)
  - ptr = 0
  - state = IDLE
  - busy = 0, wrap = 0
  - pending flag and LED direction cleared
  - buffer contents are not reset
- Reset asserted mid-fetch aborts the fetch immediately; no partial commit occurs.
- Buffer:
  - register array with combinational read; a write lands at the clock edge
  - a read in the same cycle as a write to the same address returns the old data
- Window mapping: digit NUM_DIGITS-1-i shows buf[(ptr+i) mod msg_len]. If msg_len==0, every digit shows HEX_OFF.
- FSM states: IDLE, FETCH, COMMIT.
- IDLE, with step or load sampled at edge k (load has priority when both are high):
  - step, dir=0: ptr <= (ptr+1) mod msg_len
  - step, dir=1: ptr <= (ptr==0 ? msg_len-1 : ptr-1)
  - if ptr >= msg_len (length shrank), ptr <= 0 before any advance
  - msg_len is latched; idx <= 0; state <= FETCH
- FETCH:
  - edges k+1..k+NUM_DIGITS each capture one digit into stage[idx] and increment idx
  - state <= COMMIT after idx reaches NUM_DIGITS-1
- COMMIT:
  - at edge k+NUM_DIGITS+1, current_hex <= stage
  - wrap pulses high for exactly this one cycle if the step that started this fetch wrapped the pointer (left: len-1 -> 0; right: 0 -> len-1)
  - next state is FETCH if pending is set (pending cleared), otherwise IDLE
- busy is high from the edge after k through the COMMIT edge, inclusive. Latency from step to new digits = NUM_DIGITS+1 clocks.
- step/load while busy sets a one-deep pending request recording kind (load wins) and dir. Further requests overwrite it.
- msg_len == 1: step keeps ptr = 0 and pulses wrap on every step.
- LEDR, updated on each edge with ledr_en=1, independent of the FSM:
  - rotate: shift toward the MSB; bit LED_W-1 wraps to bit 0
  - bounce: move toward the MSB until bit LED_W-1, then toward bit 0 until bit 0, then repeat
  - switching to rotate clears the direction flag to "up"; position is retained
  - current_ledr is always exactly one-hot

Decomposition:
- Shared package display_pkg:
  - HEX_* segment constants (HEX_OFF, HEX_C, HEX_P, HEX_E, HEX_N, HEX_1, HEX_3, ...)
  - LEDR_0
  - state enum {IDLE, FETCH, COMMIT}
  - CLOCK_CYCLE for benches
- One sub-module, ledr_pattern (LED_W parameter; rotate/bounce register), instantiated once.

Test Plan:
1. Reset asserted mid-FETCH (after writing any message) -> all digits HEX_OFF, current_ledr=10'b0000000001, busy=0 immediately, without waiting for a clock edge.
2. Write C,P,E,N,OFF,3,OFF,1 to addresses 0..7, msg_len=8, pulse load -> busy high for 7 clocks; after the COMMIT edge HEX5..HEX0 = C,P,E,N,OFF,3.
3. Pulse step with dir=0 -> HEX5..HEX0 = P,E,N,OFF,3,OFF. Step again with dir=1 -> display returns to C,P,E,N,OFF,3.
4. msg_len=8, ptr=7, step with dir=0 -> ptr=0, wrap high for exactly one cycle on the commit edge; HEX5..HEX0 = C,P,E,N,OFF,3.
5. Pulse step while busy, then a second step while busy -> exactly one extra fetch starts directly after COMMIT; the pointer advances twice in total.
6. led_mode=1, ledr_en held for 12 clocks from LEDR_0 -> the single set bit reaches bit 9 at clock 9, then sits at bits 8, 7, 6 on clocks 10-12. Switch to led_mode=0 and give 4 more enables -> the set bit moves to bits 7, 8, 9, then wraps to bit 0.
